// File: rtl/subpixel_interpolation.sv
// HEVC luma sub-pixel interpolation for one 8x8 block.
// Loads a 15x15 window, filters horizontally then vertically.
module subpixel_interpolation (
  input  logic          clk,
  input  logic          rst,
  input  logic [119:0]  in_row,
  output logic [63:0]   next_row,
  output logic [2559:0] out_A,
  output logic [2559:0] out_B,
  output logic [2559:0] out_C,
  output logic [7:0]    cnt,
  output logic [63:0]   fir_out_a,
  output logic [63:0]   fir_out_b,
  output logic [63:0]   fir_out_c,
  output logic [959:0]  temp_B,
  output logic          load_out,
  output logic [7:0]    sel,
  output logic [119:0]  currentPixels
);

  typedef enum logic [1:0] {LOAD, FILTER, DONE} state_t;

  state_t          state_q, state_d;
  logic [63:0]     ta_q [15];
  logic [63:0]     tb_q [15];
  logic [63:0]     tc_q [15];
  logic [63:0]     ti_q [15];
  logic [7:0]      cnt_q, sel_q;
  logic            load_q;
  logic [119:0]    cur_q;
  logic [2559:0]   oa_q, ob_q, oc_q;
  logic [63:0]     va [5];
  logic [63:0]     vb [5];
  logic [63:0]     vc [5];

  // kind: 0 quarter, 1 half, 2 three-quarter; byte t of px is sample t
  function automatic logic [7:0] fir(
    input logic [63:0] px,
    input logic [1:0]  kind
  );
    logic signed [7:0]  c [8];
    logic signed [19:0] acc;
    logic signed [19:0] sh;
    c = '{-8'sd1, 8'sd4, -8'sd10, 8'sd58, 8'sd17, -8'sd5, 8'sd1, 8'sd0};
    unique case (1'b1)
      (kind == 2'd1):
        c = '{-8'sd1, 8'sd4, -8'sd11, 8'sd40,
              8'sd40, -8'sd11, 8'sd4, -8'sd1};
      (kind == 2'd2):
        c = '{8'sd0, 8'sd1, -8'sd5, 8'sd17,
              8'sd58, -8'sd10, 8'sd4, -8'sd1};
      default: ;
    endcase
    acc = 20'sd32;
    for (int t = 0; t < 8; t++)
      acc = acc + 20'(c[t]) * 20'($signed({1'b0, px[8*t +: 8]}));
    sh = acc >>> 6;
    if (sh < 0)
      fir = 8'd0;
    else if (sh > 20'sd255)
      fir = 8'd255;
    else
      fir = sh[7:0];
  endfunction

  always_comb begin
    fir_out_a = '0;
    fir_out_b = '0;
    fir_out_c = '0;
    for (int j = 0; j < 8; j++) begin
      fir_out_a[8*j +: 8] = fir(in_row[8*j +: 64], 2'd0);
      fir_out_b[8*j +: 8] = fir(in_row[8*j +: 64], 2'd1);
      fir_out_c[8*j +: 8] = fir(in_row[8*j +: 64], 2'd2);
    end
  end

  // Column windows over stored rows sel..sel+7 for output row sel
  always_comb begin
    logic [63:0] ca, cb, cc, ci;
    logic [3:0]  idx;
    ca = '0;
    cb = '0;
    cc = '0;
    ci = '0;
    idx = '0;
    for (int k = 0; k < 5; k++) begin
      va[k] = '0;
      vb[k] = '0;
      vc[k] = '0;
    end
    for (int j = 0; j < 8; j++) begin
      for (int t = 0; t < 8; t++) begin
        idx = {1'b0, sel_q[2:0]} + 4'(t);
        ca[8*t +: 8] = ta_q[idx][8*j +: 8];
        cb[8*t +: 8] = tb_q[idx][8*j +: 8];
        cc[8*t +: 8] = tc_q[idx][8*j +: 8];
        ci[8*t +: 8] = ti_q[idx][8*j +: 8];
      end
      va[1][8*j +: 8] = fir(ca, 2'd0);
      va[2][8*j +: 8] = fir(ca, 2'd1);
      va[3][8*j +: 8] = fir(ca, 2'd2);
      va[4][8*j +: 8] = fir(ci, 2'd0);
      vb[1][8*j +: 8] = fir(cb, 2'd0);
      vb[2][8*j +: 8] = fir(cb, 2'd1);
      vb[3][8*j +: 8] = fir(cb, 2'd2);
      vb[4][8*j +: 8] = fir(ci, 2'd1);
      vc[1][8*j +: 8] = fir(cc, 2'd0);
      vc[2][8*j +: 8] = fir(cc, 2'd1);
      vc[3][8*j +: 8] = fir(cc, 2'd2);
      vc[4][8*j +: 8] = fir(ci, 2'd2);
    end
    idx = {1'b0, sel_q[2:0]} + 4'd3;
    va[0] = ta_q[idx];
    vb[0] = tb_q[idx];
    vc[0] = tc_q[idx];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD:    if (cnt_q == 8'd14) state_d = FILTER;
      FILTER:  if (sel_q == 8'd7) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      sel_q   <= '0;
      load_q  <= 1'b0;
      cur_q   <= '0;
      oa_q    <= '0;
      ob_q    <= '0;
      oc_q    <= '0;
      for (int y = 0; y < 15; y++) begin
        ta_q[y] <= '0;
        tb_q[y] <= '0;
        tc_q[y] <= '0;
        ti_q[y] <= '0;
      end
    end else begin
      state_q <= state_d;
      unique case (state_q)
        LOAD: begin
          ta_q[cnt_q[3:0]] <= fir_out_a;
          tb_q[cnt_q[3:0]] <= fir_out_b;
          tc_q[cnt_q[3:0]] <= fir_out_c;
          ti_q[cnt_q[3:0]] <= in_row[24 +: 64];
          cur_q            <= in_row;
          cnt_q            <= cnt_q + 8'd1;
        end
        FILTER: begin
          for (int i = 0; i < 8; i++) begin
            if (sel_q[2:0] == 3'(i)) begin
              for (int k = 0; k < 5; k++) begin
                oa_q[512*k + 64*i +: 64] <= va[k];
                ob_q[512*k + 64*i +: 64] <= vb[k];
                oc_q[512*k + 64*i +: 64] <= vc[k];
              end
            end
          end
          sel_q <= sel_q + 8'd1;
          if (sel_q == 8'd7) load_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    temp_B = '0;
    for (int y = 0; y < 15; y++)
      temp_B[64*y +: 64] = tb_q[y];
  end

  assign next_row      = (state_q == LOAD) ? {56'd0, cnt_q} : 64'd0;
  assign out_A         = oa_q;
  assign out_B         = ob_q;
  assign out_C         = oc_q;
  assign cnt           = cnt_q;
  assign sel           = sel_q;
  assign load_out      = load_q;
  assign currentPixels = cur_q;

endmodule

// File: tb/tb_subpixel_interpolation.sv
// Bench for subpixel_interpolation: scoreboard model
// plus spec-derived per-pixel vectors and sequencing checks.
module tb_subpixel_interpolation;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [119:0]  in_row = '0;
  logic [63:0]   next_row;
  logic [2559:0] out_A, out_B, out_C;
  logic [7:0]    cnt, sel;
  logic [63:0]   fir_out_a, fir_out_b, fir_out_c;
  logic [959:0]  temp_B;
  logic          load_out;
  logic [119:0]  currentPixels;

  always #5 clk = ~clk;

  subpixel_interpolation dut (
    .clk(clk), .rst(rst), .in_row(in_row), .next_row(next_row),
    .out_A(out_A), .out_B(out_B), .out_C(out_C), .cnt(cnt),
    .fir_out_a(fir_out_a), .fir_out_b(fir_out_b),
    .fir_out_c(fir_out_c), .temp_B(temp_B), .load_out(load_out),
    .sel(sel), .currentPixels(currentPixels)
  );

  typedef struct {
    logic [2559:0] a, b, c;
    logic [959:0]  t;
  } exp_t;

  typedef struct {
    int img; int bus; int k; int i; int j; int exp;
  } vec_t;

  int   n_chk = 0;
  int   n_pass = 0;
  int   img [15][15];
  int   taps [3][8] = '{'{-1, 4, -10, 58, 17, -5, 1, 0},
                        '{-1, 4, -11, 40, 40, -11, 4, -1},
                        '{0, 1, -5, 17, 58, -10, 4, -1}};
  exp_t sb [$];
  vec_t vecs [$];

  task automatic chk(input string name, input logic [2559:0] act,
                     input logic [2559:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else begin
      int b;
      b = 0;
      for (int i = 319; i >= 0; i--)
        if (act[8*i +: 8] !== exp[8*i +: 8]) b = i;
      $display("FAIL %s: byte %0d got %h required %h", name, b,
               act[8*b +: 8], exp[8*b +: 8]);
    end
  endtask

  function automatic int filt(input int kind, input int s[8]);
    int sum;
    sum = 32;
    for (int t = 0; t < 8; t++) sum += taps[kind][t] * s[t];
    sum = sum >>> 6;
    if (sum < 0) return 0;
    if (sum > 255) return 255;
    return sum;
  endfunction

  task automatic build(input int id);
    for (int y = 0; y < 15; y++)
      for (int x = 0; x < 15; x++)
        case (id)
          0: img[y][x] = 100;
          1: img[y][x] = 8 * x;
          2: img[y][x] = 8 * y;
          default: img[y][x] = int'($urandom_range(0, 255));
        endcase
  endtask

  function automatic logic [119:0] row_of(input int y);
    logic [119:0] r;
    for (int x = 0; x < 15; x++) r[8*x +: 8] = 8'(img[y][x]);
    return r;
  endfunction

  task automatic push_model();
    int            h [3][15][8];
    int            s [8];
    logic [2559:0] bus [3];
    exp_t          e;
    int            v;
    for (int y = 0; y < 15; y++)
      for (int j = 0; j < 8; j++) begin
        for (int t = 0; t < 8; t++) s[t] = img[y][j+t];
        for (int b = 0; b < 3; b++) h[b][y][j] = filt(b, s);
      end
    e.t = '0;
    for (int y = 0; y < 15; y++)
      for (int j = 0; j < 8; j++) e.t[64*y + 8*j +: 8] = 8'(h[1][y][j]);
    for (int b = 0; b < 3; b++) begin
      bus[b] = '0;
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 8; j++) begin
          bus[b][64*i + 8*j +: 8] = 8'(h[b][i+3][j]);
          for (int k = 1; k < 4; k++) begin
            for (int t = 0; t < 8; t++) s[t] = h[b][i+t][j];
            v = filt(k - 1, s);
            bus[b][512*k + 64*i + 8*j +: 8] = 8'(v);
          end
          for (int t = 0; t < 8; t++) s[t] = img[i+t][j+3];
          v = filt(b, s);
          bus[b][2048 + 64*i + 8*j +: 8] = 8'(v);
        end
    end
    e.a = bus[0];
    e.b = bus[1];
    e.c = bus[2];
    sb.push_back(e);
  endtask

  task automatic run(input int id, input bit seq, input bit abort);
    int            edges;
    int            held;
    exp_t          e;
    logic [2559:0] m;
    logic [2559:0] bv;
    edges = 0;
    held = 0;
    if (!abort) push_model();
    rst = 1'b0;
    in_row = '0;
    @(negedge clk);
    if (seq) begin
      chk("rst_out_A", out_A, '0);
      chk("rst_out_C", out_C, '0);
      chk("rst_temp_B", 2560'(temp_B), '0);
      chk("rst_cnt_sel_load", 2560'({cnt, sel, load_out}), '0);
      chk("rst_next_row", 2560'(next_row), '0);
    end
    rst = 1'b1;
    while (!load_out && edges < 40) begin
      if (seq && edges < 15)
        chk("next_row_seq", 2560'(next_row), 2560'(edges));
      in_row = row_of(next_row < 15 ? int'(next_row) : 0);
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (seq && edges == 15) chk("cnt_after_load", 2560'(cnt), 2560'(15));
      if (seq && edges == 22) chk("load_edge22", 2560'(load_out), '0);
      if (abort && edges == 19) begin
        chk("abort_sel", 2560'(sel), 2560'(4));
        m = '0;
        for (int k = 0; k < 5; k++)
          for (int i = 4; i < 8; i++) m[512*k + 64*i +: 64] = '1;
        chk("unwritten_rows_A", out_A & m, '0);
        chk("unwritten_rows_C", out_C & m, '0);
        #2 rst = 1'b0;
        #1;
        chk("async_out_A", out_A, '0);
        chk("async_out_B", out_B, '0);
        chk("async_out_C", out_C, '0);
        chk("async_temp_B", 2560'(temp_B), '0);
        chk("async_regs", 2560'({cnt, sel, load_out, currentPixels}), '0);
        return;
      end
    end
    chk("load_edge", 2560'(edges), 2560'(23));
    chk("sel_end", 2560'(sel), 2560'(8));
    chk("cnt_end", 2560'(cnt), 2560'(15));
    chk("currentPixels", 2560'(currentPixels), 2560'(row_of(14)));
    if (sb.size() == 0) begin
      n_chk++;
      $display("FAIL scoreboard: got empty queue required entry");
      return;
    end
    e = sb.pop_front();
    chk("sb_out_A", out_A, e.a);
    chk("sb_out_B", out_B, e.b);
    chk("sb_out_C", out_C, e.c);
    chk("sb_temp_B", 2560'(temp_B), 2560'(e.t));
    foreach (vecs[n]) begin
      if (vecs[n].img == id) begin
        bv = (vecs[n].bus == 0) ? out_A : (vecs[n].bus == 1) ? out_B : out_C;
        chk($sformatf("vec_img%0d_bus%0d_k%0d_i%0d_j%0d", id, vecs[n].bus,
                      vecs[n].k, vecs[n].i, vecs[n].j),
            2560'(bv[512*vecs[n].k + 64*vecs[n].i + 8*vecs[n].j +: 8]),
            2560'(vecs[n].exp));
      end
    end
    if (seq) begin
      for (int c = 0; c < 30; c++) begin
        in_row = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        if (load_out) held++;
      end
      chk("load_hold", 2560'(held), 2560'(30));
      chk("done_hold_A", out_A, e.a);
    end
  endtask

  initial begin
    for (int j = 0; j < 8; j++) begin
      for (int b = 0; b < 3; b++) begin
        for (int k = 0; k < 4; k++)
          vecs.push_back('{1, b, k, 7 - j, j, 8*j + 26 + 2*b});
        vecs.push_back('{1, b, 4, j, j, 8*j + 24});
      end
    end
    for (int i = 0; i < 8; i++) begin
      vecs.push_back('{2, 0, 0, i, 7 - i, 8*(i + 3)});
      vecs.push_back('{2, 0, 4, i, i, 8*i + 26});
      vecs.push_back('{2, 1, 4, i, 7 - i, 8*i + 28});
      vecs.push_back('{2, 2, 4, i, i, 8*i + 30});
    end
    for (int b = 0; b < 3; b++)
      for (int k = 0; k < 5; k++)
        vecs.push_back('{0, b, k, k, (b + k) % 8, 100});

    rst = 1'b0;
    in_row = '0;
    in_row[24 +: 8] = 8'd255;
    #1;
    chk("fir_b_j0", 2560'(fir_out_b[7:0]), 2560'(159));
    chk("fir_b_j1", 2560'(fir_out_b[15:8]), 2560'(0));
    chk("fir_b_j2", 2560'(fir_out_b[23:16]), 2560'(16));

    build(0);
    run(0, 1'b1, 1'b0);
    build(1);
    run(1, 1'b0, 1'b0);
    build(2);
    run(2, 1'b0, 1'b0);
    build(3);
    run(3, 1'b0, 1'b1);
    run(3, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/subpixel_interpolation.md
# subpixel_interpolation

HEVC luma sub-pixel interpolation engine for one 8x8 prediction block. It fetches a 15x15 integer-pixel window row by row, applies the HEVC 8-tap quarter, half and three-quarter filters horizontally, then vertically. It produces all 15 fractional positions (a..r) as three packed 2560-bit result buses. It sits between the reference-frame row store, which it addresses through `next_row`, and the motion-compensation consumer.

## Interface
Parameters: none; all sizes are fixed.

Ports:
- `clk`  in  1  sole clock, rising-edge.
- `rst`  in  1  reset; asynchronous and active-low.
- `in_row`  in  120  window row selected by `next_row`; pixel x at [8x+:8], x=0..14, unsigned.
- `next_row`  out  64  row index requested; equals `cnt` in LOAD, else 0.
- `out_A`, `out_B`, `out_C`  out  2560  five 8x8 blocks each (layout below), registered.
- `cnt`  out  8  rows loaded so far.
- `fir_out_a`, `fir_out_b`, `fir_out_c`  out  64  combinational horizontal quarter/half/three-quarter filter of `in_row`; byte j at [8j+:8].
- `temp_B`  out  960  stored horizontal half-pel rows; row y at [64y+:64].
- `load_out`  out  1  high once all outputs are valid.
- `sel`  out  8  vertical-pass output-row counter.
- `currentPixels`  out  120  last `in_row` captured.

## Operation
- Filters, with taps t0..t7:
  - QA = -1,4,-10,58,17,-5,1,0
  - HB = -1,4,-11,40,40,-11,4,-1
  - TC = 0,1,-5,17,58,-10,4,-1
- Arithmetic: signed sum of tap·sample, at least 17 bits. Result = clip((sum+32)>>>6, 0, 255), 8 bits.
- Horizontal, output column j=0..7: taps on row pixels j..j+7.
- Vertical, output row i=0..7: taps on stored rows i..i+7 of the same column.
- Output (i,j) aligns to integer pixel (i+3, j+3).
- Internal stores, 15 rows x 64 bits each:
  - tempA, tempB, tempC: horizontal results.
  - integer store: row pixels 3..10.
- Result layout: block k at bits [512k + 64i + 8j +: 8].
  - `out_A` blocks k=0..4: a = tempA row i+3; e = QA(tempA); i = HB(tempA); p = TC(tempA); d = QA(integer).
  - `out_B` blocks k=0..4: b = tempB row i+3; f = QA(tempB); j = HB(tempB); q = TC(tempB); h = HB(integer).
  - `out_C` blocks k=0..4: c = tempC row i+3; g = QA(tempC); k = HB(tempC); r = TC(tempC); n = TC(integer).
- Diagonal positions use the 8-bit clipped horizontal results as input. There is no 16-bit intermediate path.
- State LOAD, `cnt`=0..14. On each posedge:
  - row `cnt` of tempA/B/C <= `fir_out_a/b/c`.
  - integer row `cnt` <= `in_row` pixels 3..10.
  - `currentPixels` <= `in_row`.
  - `cnt` <= `cnt`+1.
  - After row 14: `cnt`=15, go to FILTER.
- State FILTER, `sel`=0..7. Each posedge writes output row `sel` of all vertical blocks, then increments `sel`.
  - Horizontal blocks (k=0) are written during this pass.
  - After `sel`=7: `sel`=8, `load_out`=1, go to DONE.
- State DONE: all outputs hold until reset. `in_row` is ignored.

## Timing
- Reset (`rst`=0): all registers, outputs, `cnt`, `sel`, `load_out`, stores and state return to 0 immediately, with state = LOAD.
- First posedge with `rst`=1 captures row 0.
- `fir_out_*` have zero latency from `in_row`. `next_row` is combinational from `cnt`.
- `load_out` rises on the 23rd posedge after reset release (15 load + 8 filter) and stays high.
- `out_*` bits outside completed rows are 0 until written.
- Reset mid-operation aborts the operation; the sequence restarts at row 0.
- `in_row` must be valid in the same cycle that `next_row` presents the index.

## Test plan
- Constant image of 100 -> after `load_out`, every byte of `out_A`/`out_B`/`out_C` = 0x64; `temp_B` all 0x64.
- Horizontal ramp, pixel(x,y)=8x -> for each column j:
  - blocks a/e/i/p = 8j+26.
  - blocks b/f/j/q = 8j+28.
  - blocks c/g/k/r = 8j+30.
  - blocks d/h/n = 8j+24.
- Column 3 = 255, all else 0 -> `fir_out_b` bytes: j0 = 159, j1 = 0 (negative sum clipped), j2 = 16.
- Sequencing: check `next_row`=0..14 on consecutive cycles; `cnt` ends at 15; `sel` ends at 8; `load_out` high exactly at the 23rd edge and held for 30 more cycles.
- Reset asserted during FILTER (`sel`=4) -> all outputs 0 asynchronously. After release, full reload; results match the uninterrupted run.
- Vertical ramp, pixel(x,y)=8y -> block a = 8(i+3); block d = 8i+26; block h = 8i+28; block n = 8i+30.
